// File: rtl/fifo_read_port.sv
// Two-entry skid buffer between an upstream FIFO and a valid/ready consumer.
// The upstream FIFO is popped whenever a slot is free, so the consumer can take one entry per cycle.
module fifo_read_port #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_valid,
  input  logic [DATA_WIDTH-1:0]  fifo_data_out,
  output logic                   fifo_pop,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] pop_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  head_q, head_d;
  logic [DATA_WIDTH-1:0]  tail_q, tail_d;
  logic [COUNT_WIDTH-1:0] pop_count_q, pop_count_d;
  logic                   xfer;

  always_comb begin
    fifo_pop    = fifo_valid & ~flush & ~rst & (state_q != TWO);
    out_valid   = (state_q != EMPTY);
    out_data    = head_q;
    xfer        = out_valid & out_ready;
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    pop_count_d = pop_count_q + {{(COUNT_WIDTH-1){1'b0}}, fifo_pop};
    unique case (state_q)
      EMPTY: if (fifo_pop) begin
        head_d  = fifo_data_out;
        state_d = ONE;
      end
      ONE: begin
        // Pop and transfer together: the new entry replaces the head directly.
        if (fifo_pop && xfer) head_d = fifo_data_out;
        else if (fifo_pop) begin
          tail_d  = fifo_data_out;
          state_d = TWO;
        end else if (xfer) state_d = EMPTY;
      end
      TWO: if (xfer) begin
        head_d  = tail_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      pop_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pop_count_q <= pop_count_d;
    end
  end

  // Payload registers carry no reset; occupancy state qualifies them.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign pop_count = pop_count_q;

endmodule
